regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file that supersedes the single-cycle 2R1W file for the dual-writeback datapath.
- Provides NUM_RD combinational read ports, two synchronous write ports with fixed priority, and optional same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard: set when issue allocates a destination, cleared on writeback. Issue logic uses it to stall on RAW hazards.
- Includes a debug read port for the board display.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = read ports see stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to 0, never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr.
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address.
- wr0_en  in  1  write port 0 enable (ALU writeback).
- wr0_addr  in  ADDR_W  write port 0 address.
- wr0_data  in  DATA_W  write port 0 data.
- wr1_en  in  1  write port 1 enable (load/multicycle writeback, higher priority).
- wr1_addr  in  ADDR_W  write port 1 address.
- wr1_data  in  DATA_W  write port 1 data.
- alloc_en  in  1  issue allocates destination register.
- alloc_addr  in  ADDR_W  destination being allocated.
- dbg_sel  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data; stored value, never bypassed.
- busy_cnt  out  ADDR_W+1  number of registers currently busy (registered).

Behaviour:
- Reset (async, immediate): all registers = 0, all busy bits = 0, busy_cnt = 0. rd_data, rd_busy and dbg_data therefore read 0 while rst is high. Clocked inputs are ignored while rst is high.
- Writes take effect at posedge clk.
- wr0 and wr1 to the same address in the same cycle: wr1 data is stored. Different addresses: both are stored.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - alloc of address 0 is dropped.
  - Reads of address 0 (read ports and debug) return 0 with busy = 0.
- Read, BYPASS=0: rd_data[k] = stored register value; purely combinational from rd_addr.
- Read, BYPASS=1: rd_data[k] returns, in priority order:
  1. wr1_data, if wr1_en and wr1_addr == rd_addr[k];
  2. wr0_data, if wr0_en and wr0_addr == rd_addr[k];
  3. the stored value otherwise.
  - The ZERO_REG rule for address 0 overrides bypass.
- Scoreboard, next-state per register r at posedge:
  - If alloc hits r: busy = 1. Alloc wins over a same-cycle writeback to r, because the new producer supersedes the old one.
  - Else if any enabled write hits r: busy = 0.
  - Else: busy holds.
- Write to a non-busy register is legal: data is stored, busy stays 0.
- rd_busy[k]:
  - BYPASS=0: rd_busy[k] = current busy bit of rd_addr[k].
  - BYPASS=1: rd_busy[k] = busy bit AND NOT (an enabled write hits rd_addr[k] this cycle). This lets issue consume the bypassed value without a stall. A same-cycle alloc does not raise rd_busy until the next cycle.
- busy_cnt is the registered population count of the next-state busy vector, updated every posedge. It is never above 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.
- No latency on reads. Write-to-stored-read latency is 1 cycle.
- Reset asserted mid-operation discards pending writes and allocs in that cycle.
- $display trace on each committed write: port, address, data. Simulation only.

Test Plan:
- Reset, then read all addresses on every port and on dbg -> all data 0, rd_busy 0, busy_cnt 0.
- wr0 r5=0x0000_1234 at cycle n; read r5 at n+1 -> 0x0000_1234. With BYPASS=1, read r5 in cycle n -> 0x0000_1234 and rd_busy 0; with BYPASS=0 -> 0.
- wr0 r7=0xAAAA_AAAA and wr1 r7=0x5555_5555 in the same cycle -> r7 = 0x5555_5555. Bypassed read that cycle -> 0x5555_5555.
- alloc r3 -> next cycle rd_busy=1 and busy_cnt=1. Then wr1 r3=0xDEAD_BEEF together with alloc r3 -> r3 = 0xDEAD_BEEF, busy stays 1, busy_cnt=1. Next wr0 r3 alone -> busy 0, busy_cnt=0.
- ZERO_REG=1: wr0 r0=0xFFFF_FFFF and alloc r0 -> read r0 = 0, rd_busy 0, busy_cnt unchanged.
- NUM_RD=4: four ports read r1, r2, r3, r1 after writes of 1, 2, 3 -> 1, 2, 3, 1. Then assert rst mid-cycle while wr0 r1=9 is pending -> all reads 0, r1 stays 0 after rst is released.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised write
// ports, optional same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  input  logic [ADDR_W-1:0]          dbg_sel,
  output logic [DATA_W-1:0]          dbg_data,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(gi);
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      logic              wr0_hit, wr1_hit, alloc_hit;
      logic [DATA_W-1:0] val_q, val_d;
      logic              bsy_q, bsy_d;

      assign wr0_hit   = !IS_ZERO && wr0_en   && (wr0_addr   == ADDR);
      assign wr1_hit   = !IS_ZERO && wr1_en   && (wr1_addr   == ADDR);
      assign alloc_hit = !IS_ZERO && alloc_en && (alloc_addr == ADDR);

      // A new allocation supersedes any writeback from the previous producer.
      always_comb begin
        val_d = val_q;
        if (wr1_hit)      val_d = wr1_data;
        else if (wr0_hit) val_d = wr0_data;
        bsy_d = bsy_q;
        if (alloc_hit)              bsy_d = 1'b1;
        else if (wr0_hit | wr1_hit) bsy_d = 1'b0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_q <= '0;
          bsy_q <= 1'b0;
        end else begin
          val_q <= val_d;
          bsy_q <= bsy_d;
        end
      end

      assign regs_q[gi] = val_q;
      assign busy_q[gi] = bsy_q;
      assign busy_d[gi] = bsy_d;
    end
  endgenerate

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero, byp0, byp1, busy;
      logic [DATA_W-1:0] data;

      assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (addr == '0);
      assign byp0    = (BYPASS != 0) && wr0_en && (wr0_addr == addr);
      assign byp1    = (BYPASS != 0) && wr1_en && (wr1_addr == addr);

      // Bypassed writes also hide the busy bit so issue can consume the value now.
      always_comb begin
        data = '0;
        busy = 1'b0;
        if (!rst && !is_zero) begin
          if (byp1)      data = wr1_data;
          else if (byp0) data = wr0_data;
          else           data = regs_q[addr];
          busy = busy_q[addr] && !(byp0 || byp1);
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi]                  = busy;
    end
  endgenerate

  assign dbg_data = (rst || ((ZERO_REG != 0) && (dbg_sel == '0))) ? '0 : regs_q[dbg_sel];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a 4-port bypassing instance and a 2-port non-bypassing
// instance share stimulus; an array model checks both every cycle.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] rd_addr = '0;
  logic        wr0_en = 1'b0, wr1_en = 1'b0, alloc_en = 1'b0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0, alloc_addr = '0, dbg_sel = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;

  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic [31:0]  dbg_data;
  logic [5:0]   busy_cnt;
  logic [63:0]  nb_rd_data;
  logic [1:0]   nb_rd_busy;
  logic [31:0]  nb_dbg_data;
  logic [5:0]   nb_busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .busy_cnt(busy_cnt)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr[9:0]), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .dbg_sel(dbg_sel), .dbg_data(nb_dbg_data), .busy_cnt(nb_busy_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays updated with the architectural write/alloc rules.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_cnt = 0;
    end else begin
      if (wr0_en && wr0_addr != 0) begin
        m_mem[wr0_addr]  = wr0_data;
        m_busy[wr0_addr] = 1'b0;
      end
      if (wr1_en && wr1_addr != 0) begin
        m_mem[wr1_addr]  = wr1_data;
        m_busy[wr1_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      if (wr0_en) $display("write port0 r%0d = %08h%s", wr0_addr, wr0_data, (wr0_addr == 0) ? " (dropped)" : "");
      if (wr1_en) $display("write port1 r%0d = %08h%s", wr1_addr, wr1_data, (wr1_addr == 0) ? " (dropped)" : "");
      m_cnt = 0;
      for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (rst || a == 0)                 return 32'h0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (rst || a == 0) return 1'b0;
    if (byp && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_data[%0d]", k), rd_data[k*32 +: 32], exp_data(rd_addr[k*5 +: 5], 1'b1));
      chk($sformatf("rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(exp_busy(rd_addr[k*5 +: 5], 1'b1)));
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("nb_rd_data[%0d]", k), nb_rd_data[k*32 +: 32], exp_data(rd_addr[k*5 +: 5], 1'b0));
      chk($sformatf("nb_rd_busy[%0d]", k), 32'(nb_rd_busy[k]), 32'(exp_busy(rd_addr[k*5 +: 5], 1'b0)));
    end
    chk("dbg_data", dbg_data, rst ? 32'h0 : m_mem[dbg_sel]);
    chk("nb_dbg_data", nb_dbg_data, rst ? 32'h0 : m_mem[dbg_sel]);
    chk("busy_cnt", 32'(busy_cnt), 32'(m_cnt));
    chk("nb_busy_cnt", 32'(nb_busy_cnt), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, a1, a2, a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    wr0_en = 1'b0;
    wr1_en = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    // Writes and allocs presented during reset must be ignored.
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hFF; alloc_en = 1'b1; alloc_addr = 5'd2;
    rd(5'd2, 5'd2, 5'd2, 5'd2);
    repeat (2) step();
    chk("lit rst rd", rd_data[31:0], 32'h0);
    chk("lit rst cnt", 32'(busy_cnt), 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      step();
      rd(a[4:0], a[4:0], a[4:0], a[4:0]);
      dbg_sel = a[4:0];
      look();
      chk("lit sweep rd", rd_data[127:96], 32'h0);
      chk("lit sweep busy", 32'(rd_busy), 32'h0);
      chk("lit sweep dbg", dbg_data, 32'h0);
    end

    step();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h0000_1234; rd(5'd5, 5'd5, 5'd5, 5'd5); dbg_sel = 5'd5;
    look();
    chk("lit byp r5", rd_data[31:0], 32'h0000_1234);
    chk("lit byp r5 busy", 32'(rd_busy[0]), 32'h0);
    chk("lit nobyp r5", nb_rd_data[31:0], 32'h0);
    chk("lit dbg r5 same cycle", dbg_data, 32'h0);
    step(); idle();
    look();
    chk("lit stored r5", rd_data[31:0], 32'h0000_1234);
    chk("lit nb stored r5", nb_rd_data[31:0], 32'h0000_1234);

    step();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA_AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555_5555;
    rd(5'd7, 5'd7, 5'd7, 5'd7); dbg_sel = 5'd7;
    look();
    chk("lit byp r7", rd_data[31:0], 32'h5555_5555);
    step(); idle();
    look();
    chk("lit dbg r7", dbg_data, 32'h5555_5555);

    step();
    alloc_en = 1'b1; alloc_addr = 5'd3; rd(5'd3, 5'd3, 5'd3, 5'd3); dbg_sel = 5'd3;
    look();
    chk("lit alloc same cycle busy", 32'(rd_busy[0]), 32'h0);
    step(); idle();
    look();
    chk("lit r3 busy", 32'(rd_busy[0]), 32'h1);
    chk("lit cnt 1", 32'(busy_cnt), 32'h1);
    step();
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hDEAD_BEEF; alloc_en = 1'b1; alloc_addr = 5'd3;
    look();
    chk("lit r3 byp busy", 32'(rd_busy[0]), 32'h0);
    chk("lit r3 nb busy", 32'(nb_rd_busy[0]), 32'h1);
    step(); idle();
    look();
    chk("lit r3 data", rd_data[31:0], 32'hDEAD_BEEF);
    chk("lit r3 still busy", 32'(rd_busy[0]), 32'h1);
    chk("lit cnt still 1", 32'(busy_cnt), 32'h1);
    step();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000_0033;
    step(); idle();
    look();
    chk("lit r3 freed", 32'(rd_busy[0]), 32'h0);
    chk("lit cnt 0", 32'(busy_cnt), 32'h0);
    chk("lit r3 new", rd_data[31:0], 32'h0000_0033);

    step();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF; alloc_en = 1'b1; alloc_addr = 5'd0;
    rd(5'd0, 5'd0, 5'd0, 5'd0); dbg_sel = 5'd0;
    look();
    chk("lit r0 byp", rd_data[31:0], 32'h0);
    step(); idle();
    look();
    chk("lit r0 stored", rd_data[31:0], 32'h0);
    chk("lit r0 busy", 32'(rd_busy[0]), 32'h0);
    chk("lit r0 cnt", 32'(busy_cnt), 32'h0);

    step();
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'd1; alloc_en = 1'b1; alloc_addr = 5'd9;
    step();
    alloc_en = 1'b0; wr0_addr = 5'd2; wr0_data = 32'd2;
    step();
    wr0_addr = 5'd3; wr0_data = 32'd3;
    step(); idle();
    rd(5'd1, 5'd2, 5'd3, 5'd1); dbg_sel = 5'd1;
    look();
    chk("lit p0 r1", rd_data[31:0], 32'd1);
    chk("lit p1 r2", rd_data[63:32], 32'd2);
    chk("lit p2 r3", rd_data[95:64], 32'd3);
    chk("lit p3 r1", rd_data[127:96], 32'd1);
    chk("lit cnt r9", 32'(busy_cnt), 32'h1);

    step();
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'd9;
    #2 rst = 1'b1;
    #1;
    chk("lit rst p0", rd_data[31:0], 32'h0);
    chk("lit rst p1", rd_data[63:32], 32'h0);
    chk("lit rst dbg", dbg_data, 32'h0);
    chk("lit rst cnt async", 32'(busy_cnt), 32'h0);
    step();
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    look();
    chk("lit r1 after rst", rd_data[31:0], 32'h0);
    chk("lit dbg r1 after rst", dbg_data, 32'h0);
    chk("lit r2 after rst", rd_data[63:32], 32'h0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
